// File: rtl/rtc_poll_seq_pkg.sv
// rtc_pkg: shared FSM encoding, error codes and RTC register layout for the poll sequencer
package rtc_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR_ISSUE,
    S_PTR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BCD = 2'd3;
  localparam logic [1:0] REG_SEC = 2'd0;
  localparam logic [1:0] REG_MIN = 2'd1;
  localparam logic [1:0] REG_HOUR = 2'd2;
  localparam int CH_BIT = 7;
  localparam int MODE_BIT = 6;
endpackage

// File: rtl/rtc_bcd_check.sv
// rtc_bcd_check: combinational BCD validator for the seconds, minutes and 24 h hours bytes
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [7:0] i_sec,
  input  logic [7:0] i_min,
  input  logic [7:0] i_hour,
  output logic       o_ok
);
  logic w_sec_ok;
  logic w_min_ok;
  logic w_hour_ok;
  logic w_unused;
  assign w_sec_ok = (i_sec[6:4] <= 3'd5) && (i_sec[3:0] <= 4'd9);
  assign w_min_ok = (i_min[6:4] <= 3'd5) && (i_min[3:0] <= 4'd9);
  assign w_hour_ok = !i_hour[MODE_BIT] && (i_hour[5:4] <= 2'd2) && (i_hour[3:0] <= 4'd9) && (i_hour[5:0] <= 6'h23);
  assign o_ok = w_sec_ok && w_min_ok && w_hour_ok;
  // CH bit and the unused top bits of minutes/hours carry no time information
  assign w_unused = &{i_sec[CH_BIT], i_min[7], i_hour[7]};
endmodule

// File: rtl/rtc_poll_seq.sv
// rtc_poll_seq: periodically reads sec/min/hour from a DS1307-class RTC and publishes a validated snapshot
module rtc_poll_seq
  import rtc_pkg::*;
#(
  parameter int POLL_CYCLES = 50_000_000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter logic [6:0] RTC_ADDR = 7'h68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_poll_now,
  output logic [6:0] o_m_addr,
  output logic [7:0] o_m_data_in,
  output logic       o_m_rw_en,
  output logic       o_m_enable,
  input  logic [7:0] i_m_data_out,
  input  logic       i_m_ready,
  input  logic       i_m_nack,
  output logic [6:0] o_sec,
  output logic [6:0] o_min,
  output logic [5:0] o_hour,
  output logic       o_time_valid,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t          r_state;
  logic [PW-1:0]   r_poll_cnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_acc;
  logic [1:0]      r_idx;
  logic [1:0]      r_code;
  logic [2:0][7:0] r_shadow;
  logic            w_trig;
  logic            w_cmpl;
  logic            w_ok;
  assign o_m_addr = RTC_ADDR;
  assign w_trig = (r_state == S_IDLE) && (i_poll_now || (i_en && r_poll_cnt == PW'(POLL_CYCLES - 1)));
  // completion only counts once the master has dropped m_ready to accept the command
  assign w_cmpl = r_acc && i_m_ready;
  rtc_bcd_check u_check (
    .i_sec (r_shadow[REG_SEC]),
    .i_min (r_shadow[REG_MIN]),
    .i_hour(r_shadow[REG_HOUR]),
    .o_ok  (w_ok)
  );
  // poll timer, transaction sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_poll_cnt <= '0;
      r_tcnt <= '0;
      r_acc <= 1'b0;
      r_idx <= '0;
      r_code <= '0;
      r_shadow <= '0;
      o_m_data_in <= '0;
      o_m_rw_en <= 1'b0;
      o_m_enable <= 1'b0;
      o_sec <= '0;
      o_min <= '0;
      o_hour <= '0;
      o_time_valid <= 1'b0;
      o_err <= 1'b0;
      o_err_code <= '0;
      o_busy <= 1'b0;
    end else begin
      o_m_enable <= 1'b0;
      o_time_valid <= 1'b0;
      o_err <= 1'b0;
      if (w_trig) r_poll_cnt <= '0;
      else if (r_state == S_IDLE && i_en) r_poll_cnt <= r_poll_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state <= S_PTR_ISSUE;
            o_busy <= 1'b1;
          end
        end
        S_PTR_ISSUE, S_RD_ISSUE: begin
          if (i_m_ready) begin
            o_m_enable <= 1'b1;
            o_m_rw_en <= (r_state == S_RD_ISSUE);
            o_m_data_in <= 8'h00;
            r_acc <= 1'b0;
            r_tcnt <= '0;
            r_state <= (r_state == S_PTR_ISSUE) ? S_PTR_WAIT : S_RD_WAIT;
          end
        end
        S_PTR_WAIT, S_RD_WAIT: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (!i_m_ready) r_acc <= 1'b1;
          if (i_m_nack) begin
            r_code <= ERR_NACK;
            r_state <= S_ERR;
          end else if (w_cmpl) begin
            if (r_state == S_PTR_WAIT) begin
              r_idx <= '0;
              r_state <= S_RD_ISSUE;
            end else begin
              r_shadow[r_idx] <= i_m_data_out;
              r_idx <= r_idx + 1'b1;
              r_state <= (r_idx < 2'd2) ? S_RD_ISSUE : S_CHECK;
            end
          end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_code <= ERR_TIMEOUT;
            r_state <= S_ERR;
          end
        end
        S_CHECK: begin
          r_code <= ERR_BCD;
          r_state <= w_ok ? S_DONE : S_ERR;
        end
        S_DONE: begin
          o_sec <= r_shadow[REG_SEC][6:0];
          o_min <= r_shadow[REG_MIN][6:0];
          o_hour <= r_shadow[REG_HOUR][5:0];
          o_time_valid <= 1'b1;
          o_busy <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          o_err <= 1'b1;
          o_err_code <= r_code;
          o_busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rtc_poll_seq.sv
// tb_rtc_poll_seq: directed tests of the RTC poll sequencer against a behavioural I2C master model
module tb_rtc_poll_seq;
  localparam int TO = 20;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst, en, poll_now;
  logic [6:0] m_addr;
  logic [7:0] m_data_in, m_data_out;
  logic m_rw_en, m_enable, m_ready, m_nack;
  logic [6:0] sec, min;
  logic [5:0] hour;
  logic time_valid, err, busy;
  logic [1:0] err_code;
  int compared = 0, mismatched = 0;
  int cyc = 0, tv_cnt = 0, err_cnt = 0, en_cnt = 0, en_cyc = 0, err_cyc = 0;
  int wr_cnt = 0, rd_cnt = 0;
  logic [7:0] last_wr;
  logic [7:0] mem [3];
  logic hang = 1'b0, nack_arm = 1'b0;
  rtc_poll_seq #(.POLL_CYCLES(100), .TIMEOUT_CYCLES(TO), .RTC_ADDR(7'h68)) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_poll_now(poll_now),
    .o_m_addr(m_addr), .o_m_data_in(m_data_in), .o_m_rw_en(m_rw_en), .o_m_enable(m_enable),
    .i_m_data_out(m_data_out), .i_m_ready(m_ready), .i_m_nack(m_nack),
    .o_sec(sec), .o_min(min), .o_hour(hour), .o_time_valid(time_valid),
    .o_err(err), .o_err_code(err_code), .o_busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_enable) begin en_cnt++; en_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (time_valid) tv_cnt++;
    end
  end
  initial begin
    int cnt;
    logic cur_rw;
    logic [7:0] cur_d;
    logic [1:0] ptr;
    cnt = 0; cur_rw = 0; cur_d = 0; ptr = 0;
    m_ready = 1'b1; m_nack = 1'b0; m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      m_nack = 1'b0;
      if (m_enable && m_ready) begin
        m_ready = 1'b0;
        cnt = LAT;
        cur_rw = m_rw_en;
        cur_d = m_data_in;
        if (cur_rw) rd_cnt++;
        else begin wr_cnt++; last_wr = cur_d; end
      end else if (!m_ready && !hang) begin
        if (cnt > 0) cnt--;
        else begin
          if (cur_rw) begin m_data_out = mem[ptr]; ptr = ptr + 2'd1; end
          else ptr = cur_d[1:0];
          m_ready = 1'b1;
          if (nack_arm) begin m_nack = 1'b1; nack_arm = 1'b0; end
        end
      end
    end
  end
  task automatic pulse_poll();
    @(negedge clk) poll_now = 1'b1;
    @(negedge clk) poll_now = 1'b0;
  endtask
  task automatic wait_end(input int tv0, input int e0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tv_cnt != tv0 || err_cnt != e0) break;
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b0; en = 1'b0; poll_now = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if ({sec, min, hour} !== 20'h0) begin mismatched++; $display("FAIL reset_time got %h want 0", {sec, min, hour}); end
    compared++; if ({time_valid, err, err_code, busy, m_enable, m_rw_en} !== 7'h0) begin mismatched++; $display("FAIL reset_ctrl got %b want 0", {time_valid, err, err_code, busy, m_enable, m_rw_en}); end
    compared++; if (m_data_in !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", m_data_in); end
    compared++; if (m_addr !== 7'h68) begin mismatched++; $display("FAIL addr got %h want 68", m_addr); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic();
    int tv0, e0, w0, r0;
    mem[0] = 8'h45; mem[1] = 8'h59; mem[2] = 8'h23;
    tv0 = tv_cnt; e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
    pulse_poll();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_start got %b want 1", busy); end
    wait_end(tv0, e0);
    compared++; if ({sec, min, hour} !== {7'h45, 7'h59, 6'h23}) begin mismatched++; $display("FAIL basic_time got %h %h %h want 45 59 23", sec, min, hour); end
    compared++; if (tv_cnt - tv0 !== 1) begin mismatched++; $display("FAIL basic_tv got %0d want 1", tv_cnt - tv0); end
    compared++; if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL basic_err got %0d want 0", err_cnt - e0); end
    compared++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 3) begin mismatched++; $display("FAIL basic_xfers got w%0d r%0d want w1 r3", wr_cnt - w0, rd_cnt - r0); end
    compared++; if (last_wr !== 8'h00) begin mismatched++; $display("FAIL basic_ptr got %h want 00", last_wr); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask
  task automatic test_ch_strip();
    int tv0, e0;
    mem[0] = 8'hB0;
    tv0 = tv_cnt; e0 = err_cnt;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (sec !== 7'h30) begin mismatched++; $display("FAIL ch_sec got %h want 30", sec); end
    compared++; if (tv_cnt - tv0 !== 1) begin mismatched++; $display("FAIL ch_tv got %0d want 1", tv_cnt - tv0); end
  endtask
  task automatic test_bad_data();
    int tv0, e0;
    mem[0] = 8'h11; mem[1] = 8'h5A; mem[2] = 8'h23;
    tv0 = tv_cnt; e0 = err_cnt;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (err_cnt - e0 !== 1 || err_code !== 2'd3) begin mismatched++; $display("FAIL bad_min got n%0d code %0d want n1 code 3", err_cnt - e0, err_code); end
    compared++; if ({sec, min, hour} !== {7'h30, 7'h59, 6'h23} || tv_cnt != tv0) begin mismatched++; $display("FAIL bad_min_hold got %h %h %h tv%0d want 30 59 23 tv0", sec, min, hour, tv_cnt - tv0); end
    mem[1] = 8'h07; mem[2] = 8'h52;
    tv0 = tv_cnt; e0 = err_cnt;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (err_cnt - e0 !== 1 || err_code !== 2'd3) begin mismatched++; $display("FAIL bad_hour got n%0d code %0d want n1 code 3", err_cnt - e0, err_code); end
    compared++; if ({sec, min, hour} !== {7'h30, 7'h59, 6'h23} || tv_cnt != tv0) begin mismatched++; $display("FAIL bad_hour_hold got %h %h %h want 30 59 23", sec, min, hour); end
  endtask
  task automatic test_nack();
    int tv0, e0, r0;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    tv0 = tv_cnt; e0 = err_cnt; r0 = rd_cnt;
    nack_arm = 1'b1;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (err_cnt - e0 !== 1 || err_code !== 2'd1) begin mismatched++; $display("FAIL nack_err got n%0d code %0d want n1 code 1", err_cnt - e0, err_code); end
    compared++; if (rd_cnt != r0 || busy !== 1'b0) begin mismatched++; $display("FAIL nack_reads got %0d busy %b want 0 busy 0", rd_cnt - r0, busy); end
    repeat (10) @(negedge clk);
    compared++; if (err_code !== 2'd1) begin mismatched++; $display("FAIL nack_code_hold got %0d want 1", err_code); end
    tv0 = tv_cnt; e0 = err_cnt;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (tv_cnt - tv0 !== 1 || {sec, min, hour} !== {7'h01, 7'h02, 6'h03}) begin mismatched++; $display("FAIL nack_recover got tv%0d %h %h %h want tv1 01 02 03", tv_cnt - tv0, sec, min, hour); end
  endtask
  task automatic test_timeout();
    int tv0, e0;
    tv0 = tv_cnt; e0 = err_cnt;
    hang = 1'b1;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (err_cnt - e0 !== 1 || err_code !== 2'd2) begin mismatched++; $display("FAIL timeout_err got n%0d code %0d want n1 code 2", err_cnt - e0, err_code); end
    compared++; if (err_cyc - en_cyc !== TO + 1) begin mismatched++; $display("FAIL timeout_latency got %0d want %0d", err_cyc - en_cyc, TO + 1); end
    hang = 1'b0;
    repeat (10) @(negedge clk);
    mem[0] = 8'h09; mem[1] = 8'h10; mem[2] = 8'h20;
    tv0 = tv_cnt; e0 = err_cnt;
    pulse_poll();
    wait_end(tv0, e0);
    compared++; if (tv_cnt - tv0 !== 1 || {sec, min, hour} !== {7'h09, 7'h10, 6'h20}) begin mismatched++; $display("FAIL timeout_recover got tv%0d %h %h %h want tv1 09 10 20", tv_cnt - tv0, sec, min, hour); end
  endtask
  task automatic test_periodic();
    int n, tv0, e0;
    en = 1'b1;
    for (int i = 0; i < 500 && !busy; i++) @(negedge clk);
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 1000 && !busy; i++) begin n++; @(negedge clk); end
    compared++; if (n !== 100) begin mismatched++; $display("FAIL period_idle got %0d want 100", n); end
    tv0 = tv_cnt;
    @(negedge clk) poll_now = 1'b1;
    @(negedge clk) poll_now = 1'b0;
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 1000 && !busy; i++) begin n++; @(negedge clk); end
    compared++; if (n !== 100 || tv_cnt - tv0 !== 1) begin mismatched++; $display("FAIL busy_poll_now got idle %0d tv%0d want idle 100 tv1", n, tv_cnt - tv0); end
    en = 1'b0;
    tv0 = tv_cnt; e0 = err_cnt;
    wait_end(tv0, e0);
  endtask
  task automatic test_reset_mid();
    int tv0, e0, r0, n0;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h15;
    r0 = rd_cnt;
    pulse_poll();
    for (int i = 0; i < 500 && rd_cnt == r0; i++) @(negedge clk);
    hang = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    compared++; if ({sec, min, hour, err_code} !== 22'h0) begin mismatched++; $display("FAIL midrst_time got %h %h %h code %0d want 0", sec, min, hour, err_code); end
    compared++; if ({busy, m_enable, m_rw_en, m_data_in} !== 11'h0) begin mismatched++; $display("FAIL midrst_ctrl got %b want 0", {busy, m_enable, m_rw_en, m_data_in}); end
    rst = 1'b1;
    n0 = en_cnt;
    pulse_poll();
    repeat (15) @(negedge clk);
    compared++; if (en_cnt != n0 || busy !== 1'b1) begin mismatched++; $display("FAIL midrst_noissue got en%0d busy %b want en0 busy 1", en_cnt - n0, busy); end
    tv0 = tv_cnt; e0 = err_cnt;
    hang = 1'b0;
    wait_end(tv0, e0);
    compared++; if (tv_cnt - tv0 !== 1 || {sec, min, hour} !== {7'h12, 7'h34, 6'h15}) begin mismatched++; $display("FAIL midrst_recover got tv%0d %h %h %h want tv1 12 34 15", tv_cnt - tv0, sec, min, hour); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_ch_strip();
    test_bad_data();
    test_nack();
    test_timeout();
    test_periodic();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
